bus_dma_master: RTL

Bus initiator that copies a block of 64-bit doublewords from a source address to a destination address over the system bus. It drives addr, data_in, rd_ctrl and wr_ctrl toward the bus decoder, and samples data_out and valid from it. It shares the bus with the CPU through a req/gnt pair and reports completion or decode errors back to the core.

---
 rtl/bus_dma_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/bus_dma_master.sv
// Bus DMA initiator: copies len doublewords src->dst over the shared bus (optional irq under DMA_IRQ_EN).
// Latency: one ARB cycle, then one doubleword per RD_WAIT+1 cycles under continuous grant, then one DONE/ERR cycle.
// Backpressure: bus_gnt low holds in ARB; a lost grant drops the current beat, which is retried after re-grant.
module bus_dma_master #(
    parameter int         LEN_W   = 16,
    parameter int         RD_WAIT = 1,
    parameter logic [2:0] RD_CODE = 3'b111,
    parameter logic [2:0] WR_CODE = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      src,
    input  logic [63:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [63:0]      err_addr,
`ifdef DMA_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [63:0]      bus_addr,
    output logic [63:0]      bus_wdata,
    output logic [2:0]       bus_rd_ctrl,
    output logic [2:0]       bus_wr_ctrl,
    input  logic [63:0]      bus_rdata,
    input  logic             bus_valid
);

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_WR, S_DONE, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [63:0]      cur_src, cur_dst, rd_buf;
    logic [LEN_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             phase_wr;
    logic             rd_last;

    assign rd_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        bus_req     = 1'b0;
        bus_addr    = '0;
        bus_wdata   = '0;
        bus_rd_ctrl = 3'b000;
        bus_wr_ctrl = 3'b000;
        case (state)
            S_IDLE: if (start) begin
                if (src[2:0] != 3'b000 || dst[2:0] != 3'b000) state_nxt = S_ERR;
                else if (len == '0)                           state_nxt = S_DONE;
                else                                          state_nxt = S_ARB;
            end
            S_ARB: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) state_nxt = phase_wr ? S_WR : S_RD;
            end
            S_RD: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (!bus_gnt) begin
                    state_nxt = S_ARB;
                end else begin
                    bus_addr    = cur_src;
                    bus_rd_ctrl = RD_CODE;
                    if (rd_last) state_nxt = bus_valid ? S_WR : S_ERR;
                end
            end
            S_WR: begin
                busy    = 1'b1;
                bus_req = 1'b1;
                if (!bus_gnt) begin
                    state_nxt = S_ARB;
                end else begin
                    bus_addr    = cur_dst;
                    bus_wdata   = rd_buf;
                    bus_wr_ctrl = WR_CODE;
                    if (!bus_valid)               state_nxt = S_ERR;
                    else if (rem == LEN_W'(1))    state_nxt = S_DONE;
                    else                          state_nxt = S_RD;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Phase survives a lost grant so ARB resumes the interrupted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src  <= '0;
            cur_dst  <= '0;
            rd_buf   <= '0;
            rem      <= '0;
            cnt      <= '0;
            phase_wr <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    err_addr <= '0;
                    if (src[2:0] != 3'b000) begin
                        err_addr <= src;
                    end else if (dst[2:0] != 3'b000) begin
                        err_addr <= dst;
                    end else begin
                        cur_src  <= src;
                        cur_dst  <= dst;
                        rem      <= len;
                        phase_wr <= 1'b0;
                    end
                end
                S_ARB: cnt <= '0;
                S_RD: if (bus_gnt) begin
                    if (rd_last) begin
                        if (bus_valid) begin
                            rd_buf   <= bus_rdata;
                            phase_wr <= 1'b1;
                        end else begin
                            err_addr <= cur_src;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR: if (bus_gnt) begin
                    if (bus_valid) begin
                        rem      <= rem - LEN_W'(1);
                        cur_src  <= cur_src + 64'd8;
                        cur_dst  <= cur_dst + 64'd8;
                        phase_wr <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        err_addr <= cur_dst;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           irq <= 1'b0;
        else if (done || err) irq <= 1'b1;
        else if (irq_clr)     irq <= 1'b0;
    end
`endif

endmodule
